// File: rtl/cksum_sched_pkg.sv
// Shared types and widths for the checksum job scheduler.
// Bus widths, FSM/grant encodings and the queued job record.
package cksum_sched_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int JOB_W    = ADDR_BUS + DATA_BUS + ADDR_BUS;

  typedef enum logic [1:0] {
    SCHED_STATE_IDLE    = 2'd0,
    SCHED_STATE_ARM     = 2'd1,
    SCHED_STATE_RUN     = 2'd2,
    SCHED_STATE_RELEASE = 2'd3
  } sched_state_e;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_ENG  = 1'b1
  } gnt_e;

  typedef struct packed {
    logic [ADDR_BUS-1:0] field_start;
    logic [DATA_BUS-1:0] field_len;
    logic [ADDR_BUS-1:0] dst;
  } job_t;

  // A zero-length job carries no work and is discarded with an error pulse.
  function automatic logic job_is_valid(input job_t j);
    return j.field_len != '0;
  endfunction

endpackage

// File: rtl/cksum_sched_if.sv
// Bundle of the scheduler's job, engine, host and memory-port signals.
// The slave modport is the scheduler's view; master is the surrounding system.
interface cksum_sched_if;
  import cksum_sched_pkg::*;

  logic                job_valid_i;
  logic                job_ready_o;
  logic [ADDR_BUS-1:0] job_field_start_i;
  logic [ADDR_BUS-1:0] job_dst_i;
  logic [DATA_BUS-1:0] job_field_len_i;

  logic                eng_start_o;
  logic [ADDR_BUS-1:0] eng_field_start_o;
  logic [ADDR_BUS-1:0] eng_dst_o;
  logic [DATA_BUS-1:0] eng_field_len_o;
  logic                eng_ready_i;

  logic                eng_mem_ce_i;
  logic                eng_mem_we_i;
  logic [ADDR_BUS-1:0] eng_mem_addr_i;
  logic [3:0]          eng_mem_width_i;
  logic [DATA_BUS-1:0] eng_mem_data_i;
  logic [DATA_BUS-1:0] eng_mem_data_o;

  logic                host_mem_ce_i;
  logic                host_mem_we_i;
  logic [ADDR_BUS-1:0] host_mem_addr_i;
  logic [3:0]          host_mem_width_i;
  logic [DATA_BUS-1:0] host_mem_data_i;
  logic [DATA_BUS-1:0] host_mem_data_o;
  logic                host_stall_o;

  logic                mem_ce_o;
  logic                mem_we_o;
  logic [ADDR_BUS-1:0] mem_addr_o;
  logic [3:0]          mem_width_o;
  logic [DATA_BUS-1:0] mem_data_o;
  logic [DATA_BUS-1:0] mem_data_i;

  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic [15:0]         jobs_done_o;

  modport slave (
    input  job_valid_i, job_field_start_i, job_dst_i, job_field_len_i,
    output job_ready_o,
    output eng_start_o, eng_field_start_o, eng_dst_o, eng_field_len_o,
    input  eng_ready_i,
    input  eng_mem_ce_i, eng_mem_we_i, eng_mem_addr_i, eng_mem_width_i, eng_mem_data_i,
    output eng_mem_data_o,
    input  host_mem_ce_i, host_mem_we_i, host_mem_addr_i, host_mem_width_i, host_mem_data_i,
    output host_mem_data_o, host_stall_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    input  mem_data_i,
    output busy_o, done_o, err_o, jobs_done_o
  );

  modport master (
    output job_valid_i, job_field_start_i, job_dst_i, job_field_len_i,
    input  job_ready_o,
    input  eng_start_o, eng_field_start_o, eng_dst_o, eng_field_len_o,
    output eng_ready_i,
    output eng_mem_ce_i, eng_mem_we_i, eng_mem_addr_i, eng_mem_width_i, eng_mem_data_i,
    input  eng_mem_data_o,
    output host_mem_ce_i, host_mem_we_i, host_mem_addr_i, host_mem_width_i, host_mem_data_i,
    input  host_mem_data_o, host_stall_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    output mem_data_i,
    input  busy_o, done_o, err_o, jobs_done_o
  );

endinterface

// File: rtl/sched_fifo.sv
// Synchronous circular FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate count.
module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/cksum_sched.sv
// Checksum job scheduler: queues jobs, issues them to the engine with a
// start/ready handshake, and arbitrates the shared packet-memory port.
module cksum_sched
  import cksum_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  cksum_sched_if.slave bus
);

  sched_state_e        state_q, state_d;
  gnt_e                gnt_q, gnt_d;
  logic [ADDR_BUS-1:0] eng_field_start_q, eng_field_start_d;
  logic [ADDR_BUS-1:0] eng_dst_q, eng_dst_d;
  logic [DATA_BUS-1:0] eng_field_len_q, eng_field_len_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         jobs_done_q, jobs_done_d;

  job_t fifo_in;
  job_t head_job;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_in.field_start = bus.job_field_start_i;
  assign fifo_in.field_len   = bus.job_field_len_i;
  assign fifo_in.dst         = bus.job_dst_i;

  sched_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.job_valid_i),
    .pop_i   (fifo_pop),
    .data_i  (fifo_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_job)
  );

  // Next-state logic; popping a valid head always latches it onto eng_*.
  always_comb begin
    state_d           = state_q;
    fifo_pop          = 1'b0;
    done_d            = 1'b0;
    err_d             = 1'b0;
    jobs_done_d       = jobs_done_q;
    eng_field_start_d = eng_field_start_q;
    eng_field_len_d   = eng_field_len_q;
    eng_dst_d         = eng_dst_q;

    case (state_q)
      SCHED_STATE_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (job_is_valid(head_job)) begin
            state_d           = SCHED_STATE_ARM;
            eng_field_start_d = head_job.field_start;
            eng_field_len_d   = head_job.field_len;
            eng_dst_d         = head_job.dst;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCHED_STATE_ARM: begin
        state_d = SCHED_STATE_RUN;
      end
      SCHED_STATE_RUN: begin
        if (bus.eng_ready_i) begin
          state_d     = SCHED_STATE_RELEASE;
          done_d      = 1'b1;
          jobs_done_d = jobs_done_q + 16'd1;
        end
      end
      SCHED_STATE_RELEASE: begin
        // Zero-length heads fall back to IDLE, which discards them.
        if (!fifo_empty && job_is_valid(head_job)) begin
          fifo_pop          = 1'b1;
          state_d           = SCHED_STATE_ARM;
          eng_field_start_d = head_job.field_start;
          eng_field_len_d   = head_job.field_len;
          eng_dst_d         = head_job.dst;
        end else begin
          state_d = SCHED_STATE_IDLE;
        end
      end
      default: begin
        state_d = SCHED_STATE_IDLE;
      end
    endcase

    gnt_d = (state_d == SCHED_STATE_IDLE) ? GNT_HOST : GNT_ENG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= SCHED_STATE_IDLE;
      gnt_q             <= GNT_HOST;
      eng_field_start_q <= '0;
      eng_field_len_q   <= '0;
      eng_dst_q         <= '0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      jobs_done_q       <= '0;
    end else begin
      state_q           <= state_d;
      gnt_q             <= gnt_d;
      eng_field_start_q <= eng_field_start_d;
      eng_field_len_q   <= eng_field_len_d;
      eng_dst_q         <= eng_dst_d;
      done_q            <= done_d;
      err_q             <= err_d;
      jobs_done_q       <= jobs_done_d;
    end
  end

  assign bus.job_ready_o       = !fifo_full;
  assign bus.eng_start_o       = (state_q == SCHED_STATE_ARM) || (state_q == SCHED_STATE_RUN);
  assign bus.eng_field_start_o = eng_field_start_q;
  assign bus.eng_field_len_o   = eng_field_len_q;
  assign bus.eng_dst_o         = eng_dst_q;
  assign bus.busy_o            = (state_q != SCHED_STATE_IDLE) || !fifo_empty;
  assign bus.done_o            = done_q;
  assign bus.err_o             = err_q;
  assign bus.jobs_done_o       = jobs_done_q;
  assign bus.eng_mem_data_o    = bus.mem_data_i;
  assign bus.host_mem_data_o   = bus.mem_data_i;

  // Memory port follows the registered grant; a host request under an
  // engine grant is stalled and must be held by the host.
  always_comb begin
    bus.mem_ce_o     = bus.host_mem_ce_i;
    bus.mem_we_o     = bus.host_mem_we_i;
    bus.mem_addr_o   = bus.host_mem_addr_i;
    bus.mem_width_o  = bus.host_mem_width_i;
    bus.mem_data_o   = bus.host_mem_data_i;
    bus.host_stall_o = 1'b0;
    if (gnt_q == GNT_ENG) begin
      bus.mem_ce_o     = bus.eng_mem_ce_i;
      bus.mem_we_o     = bus.eng_mem_we_i;
      bus.mem_addr_o   = bus.eng_mem_addr_i;
      bus.mem_width_o  = bus.eng_mem_width_i;
      bus.mem_data_o   = bus.eng_mem_data_i;
      bus.host_stall_o = bus.host_mem_ce_i;
    end
  end

endmodule

// File: tb/tb_cksum_sched.sv
// Self-checking bench for cksum_sched: engine model with a job scoreboard,
// a memory-mux vector table and hand-written multi-cycle sequences.
module tb_cksum_sched;
  import cksum_sched_pkg::*;

  typedef struct {
    logic        host_ce;
    logic        host_we;
    logic [31:0] host_addr;
    logic [3:0]  host_width;
    logic [31:0] host_wdata;
    logic        eng_ce;
    logic [31:0] eng_addr;
    logic [31:0] rdata;
    logic        exp_ce;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_width;
    logic [31:0] exp_wdata;
    logic        exp_stall;
  } mux_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cksum_sched_if bus();

  cksum_sched #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Engine-model state and statistics.
  job_t exp_q[$];
  job_t cur_job;
  int   gap_q[$];
  int   cyc = 0;
  int   starts = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   hi_cnt = 0;
  int   last_high = 0;
  int   last_fall_cyc = 0;
  int   last_done_cyc = 0;
  int   run_cnt = 0;
  int   ready_delay = 12;
  logic force_ready = 1'b0;
  logic start_prev = 1'b0;
  logic ready_prev = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Engine model: checks each started job against the scoreboard, raises
  // ready ready_delay cycles after start is first seen, and records timing.
  always @(negedge clk) begin
    cyc++;
    if (bus.done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
      check_output("done_after_ready", 64'(ready_prev), 64'(1'b1));
    end
    if (bus.err_o) err_cnt++;
    if (bus.eng_start_o && !start_prev) begin
      starts++;
      gap_q.push_back(cyc - last_fall_cyc);
      hi_cnt  = 1;
      run_cnt = 0;
      if (exp_q.size() == 0) begin
        check_output("sb_unexpected_start", 64'(starts), 64'(0));
      end else begin
        cur_job = exp_q.pop_front();
        check_output("sb_field_start", 64'(bus.eng_field_start_o), 64'(cur_job.field_start));
        check_output("sb_field_len", 64'(bus.eng_field_len_o), 64'(cur_job.field_len));
        check_output("sb_dst", 64'(bus.eng_dst_o), 64'(cur_job.dst));
      end
    end else if (bus.eng_start_o) begin
      hi_cnt++;
      run_cnt++;
    end
    if (!bus.eng_start_o && start_prev) begin
      last_high     = hi_cnt;
      last_fall_cyc = cyc;
      if (!rst) begin
        check_output("hold_field_start", 64'(bus.eng_field_start_o), 64'(cur_job.field_start));
        check_output("hold_dst", 64'(bus.eng_dst_o), 64'(cur_job.dst));
      end
    end
    bus.eng_ready_i = force_ready || (bus.eng_start_o && (run_cnt >= ready_delay));
    ready_prev = bus.eng_ready_i;
    start_prev = bus.eng_start_o;
  end

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_job(input logic [31:0] s, input logic [31:0] l, input logic [31:0] d);
    job_t j;
    int   n = 0;
    tick();
    bus.job_valid_i       = 1'b1;
    bus.job_field_start_i = s;
    bus.job_field_len_i   = l;
    bus.job_dst_i         = d;
    while (!bus.job_ready_o && n < 300) begin
      tick();
      n++;
    end
    if (!bus.job_ready_o) check_output("push_timeout", 64'(bus.job_ready_o), 64'(1'b1));
    @(posedge clk);
    #1;
    bus.job_valid_i = 1'b0;
    j.field_start = s;
    j.field_len   = l;
    j.dst         = d;
    if (l != 0) exp_q.push_back(j);
  endtask

  task automatic wait_for_start(input int base, input string name);
    int n = 0;
    while (starts <= base && n < 200) begin
      tick();
      n++;
    end
    check_output(name, 64'(starts > base), 64'(1'b1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.busy_o || bus.eng_start_o) && n < 600) begin
      tick();
      n++;
    end
    tick();
    check_output(name, 64'(bus.busy_o), 64'(1'b0));
  endtask

  task automatic apply_stimulus(input mux_vec_t v);
    bus.host_mem_ce_i    = v.host_ce;
    bus.host_mem_we_i    = v.host_we;
    bus.host_mem_addr_i  = v.host_addr;
    bus.host_mem_width_i = v.host_width;
    bus.host_mem_data_i  = v.host_wdata;
    bus.eng_mem_ce_i     = v.eng_ce;
    bus.eng_mem_we_i     = 1'b1;
    bus.eng_mem_addr_i   = v.eng_addr;
    bus.eng_mem_width_i  = 4'h1;
    bus.eng_mem_data_i   = 32'h0BAD_0BAD;
    bus.mem_data_i       = v.rdata;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mux_vec_t vecs[3];
    int base;
    int dcnt;
    int ecnt;
    int gidx;
    int n;
    logic stalled_ok;

    rst = 1'b1;
    bus.job_valid_i = 1'b0;
    bus.job_field_start_i = '0;
    bus.job_field_len_i = '0;
    bus.job_dst_i = '0;
    bus.eng_ready_i = 1'b0;
    bus.eng_mem_ce_i = 1'b0;
    bus.eng_mem_we_i = 1'b0;
    bus.eng_mem_addr_i = '0;
    bus.eng_mem_width_i = '0;
    bus.eng_mem_data_i = '0;
    bus.host_mem_ce_i = 1'b0;
    bus.host_mem_we_i = 1'b0;
    bus.host_mem_addr_i = 32'h55;
    bus.host_mem_width_i = 4'h2;
    bus.host_mem_data_i = '0;
    bus.mem_data_i = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 4'h4, 32'h0, 1'b1, 32'h999, 32'hCAFE_0001,
                1'b1, 1'b0, 32'h100, 4'h4, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h204, 4'hF, 32'h1234_5678, 1'b1, 32'h888, 32'h0000_00FF,
                1'b1, 1'b1, 32'h204, 4'hF, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h300, 4'h1, 32'hAAAA_5555, 1'b1, 32'h777, 32'h8000_0000,
                1'b0, 1'b0, 32'h300, 4'h1, 32'hAAAA_5555, 1'b0};

    repeat (2) tick();

    // Reset values.
    check_output("rst_job_ready", 64'(bus.job_ready_o), 64'(1'b1));
    check_output("rst_start", 64'(bus.eng_start_o), 64'(1'b0));
    check_output("rst_eng_start_addr", 64'(bus.eng_field_start_o), 64'(0));
    check_output("rst_eng_len", 64'(bus.eng_field_len_o), 64'(0));
    check_output("rst_busy", 64'(bus.busy_o), 64'(1'b0));
    check_output("rst_done", 64'(bus.done_o), 64'(1'b0));
    check_output("rst_err", 64'(bus.err_o), 64'(1'b0));
    check_output("rst_jobs_done", 64'(bus.jobs_done_o), 64'(0));
    check_output("rst_stall", 64'(bus.host_stall_o), 64'(1'b0));
    check_output("rst_mem_addr_host", 64'(bus.mem_addr_o), 64'(32'h55));
    rst = 1'b0;
    tick();

    // Memory mux under the host grant.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output("mux_ce", 64'(bus.mem_ce_o), 64'(vecs[i].exp_ce));
      check_output("mux_we", 64'(bus.mem_we_o), 64'(vecs[i].exp_we));
      check_output("mux_addr", 64'(bus.mem_addr_o), 64'(vecs[i].exp_addr));
      check_output("mux_width", 64'(bus.mem_width_o), 64'(vecs[i].exp_width));
      check_output("mux_wdata", 64'(bus.mem_data_o), 64'(vecs[i].exp_wdata));
      check_output("mux_stall", 64'(bus.host_stall_o), 64'(vecs[i].exp_stall));
      check_output("mux_eng_rdata", 64'(bus.eng_mem_data_o), 64'(vecs[i].rdata));
      check_output("mux_host_rdata", 64'(bus.host_mem_data_o), 64'(vecs[i].rdata));
    end
    apply_stimulus('{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0});

    // Single job: two-edge start latency, 13 start-high cycles, one done.
    ready_delay = 12;
    dcnt = done_cnt;
    push_job(32'h10, 32'd20, 32'h1A);
    tick();
    check_output("lat_start_after_push", 64'(bus.eng_start_o), 64'(1'b0));
    check_output("lat_busy_after_push", 64'(bus.busy_o), 64'(1'b1));
    tick();
    check_output("lat_start_after_pop", 64'(bus.eng_start_o), 64'(1'b1));
    wait_idle("single_idle");
    check_output("single_start_high", 64'(last_high), 64'(13));
    check_output("single_done_cnt", 64'(done_cnt - dcnt), 64'(1));
    check_output("single_jobs_done", 64'(bus.jobs_done_o), 64'(1));
    bus.host_mem_ce_i = 1'b1;
    bus.host_mem_addr_i = 32'h77;
    #1;
    check_output("single_gnt_host_stall", 64'(bus.host_stall_o), 64'(1'b0));
    check_output("single_gnt_host_addr", 64'(bus.mem_addr_o), 64'(32'h77));
    bus.host_mem_ce_i = 1'b0;

    // Five back-to-back jobs against a depth-4 FIFO.
    do_reset();
    ready_delay = 6;
    base = starts;
    gidx = gap_q.size();
    for (int i = 0; i < 5; i++) push_job(32'h100 + 32'(i), 32'd4 + 32'(i), 32'h200 + 32'(i));
    check_output("b2b_full_ready", 64'(bus.job_ready_o), 64'(1'b0));
    wait_idle("b2b_idle");
    check_output("b2b_starts", 64'(starts - base), 64'(5));
    check_output("b2b_jobs_done", 64'(bus.jobs_done_o), 64'(5));
    check_output("b2b_sb_empty", 64'(exp_q.size()), 64'(0));
    for (int i = gidx + 1; i < gap_q.size(); i++) check_output("b2b_gap", 64'(gap_q[i]), 64'(1));

    // Zero-length job between two valid jobs.
    do_reset();
    ready_delay = 3;
    base = starts;
    ecnt = err_cnt;
    push_job(32'h30, 32'd8, 32'h3A);
    push_job(32'h31, 32'd0, 32'h3B);
    push_job(32'h32, 32'd4, 32'h3C);
    wait_idle("zero_idle");
    check_output("zero_err_cnt", 64'(err_cnt - ecnt), 64'(1));
    check_output("zero_starts", 64'(starts - base), 64'(2));
    check_output("zero_jobs_done", 64'(bus.jobs_done_o), 64'(2));
    check_output("zero_sb_empty", 64'(exp_q.size()), 64'(0));

    // Host write during RUN stalls until the cycle after RELEASE->IDLE.
    do_reset();
    ready_delay = 10;
    base = starts;
    push_job(32'h50, 32'd16, 32'h5A);
    wait_for_start(base, "host_start_seen");
    tick();
    tick();
    bus.host_mem_ce_i = 1'b1;
    bus.host_mem_we_i = 1'b1;
    bus.host_mem_addr_i = 32'h40;
    bus.host_mem_width_i = 4'hF;
    bus.host_mem_data_i = 32'hDEAD_BEEF;
    bus.eng_mem_ce_i = 1'b1;
    bus.eng_mem_we_i = 1'b0;
    bus.eng_mem_addr_i = 32'h99;
    bus.eng_mem_width_i = 4'h3;
    tick();
    check_output("host_run_stall", 64'(bus.host_stall_o), 64'(1'b1));
    check_output("host_run_mem_addr", 64'(bus.mem_addr_o), 64'(32'h99));
    check_output("host_run_mem_we", 64'(bus.mem_we_o), 64'(1'b0));
    stalled_ok = 1'b1;
    n = 0;
    while (bus.host_stall_o && n < 50) begin
      if (bus.mem_addr_o !== 32'h99 || bus.mem_we_o !== 1'b0) stalled_ok = 1'b0;
      tick();
      n++;
    end
    check_output("host_stall_released", 64'(bus.host_stall_o), 64'(1'b0));
    check_output("host_no_leak_while_stalled", 64'(stalled_ok), 64'(1'b1));
    check_output("host_release_cycle", 64'(cyc), 64'(last_done_cyc + 1));
    check_output("host_write_addr", 64'(bus.mem_addr_o), 64'(32'h40));
    check_output("host_write_we", 64'(bus.mem_we_o), 64'(1'b1));
    check_output("host_write_data", 64'(bus.mem_data_o), 64'(32'hDEAD_BEEF));
    check_output("host_write_width", 64'(bus.mem_width_o), 64'(4'hF));
    bus.host_mem_ce_i = 1'b0;
    bus.host_mem_we_i = 1'b0;
    bus.eng_mem_ce_i = 1'b0;

    // Reset asserted in RUN with two jobs queued.
    do_reset();
    ready_delay = 30;
    base = starts;
    push_job(32'h60, 32'd8, 32'h6A);
    push_job(32'h61, 32'd8, 32'h6B);
    push_job(32'h62, 32'd8, 32'h6C);
    tick();
    tick();
    check_output("rstrun_in_run", 64'(bus.eng_start_o), 64'(1'b1));
    dcnt = done_cnt;
    ecnt = err_cnt;
    rst = 1'b1;
    tick();
    check_output("rstrun_start", 64'(bus.eng_start_o), 64'(1'b0));
    check_output("rstrun_busy", 64'(bus.busy_o), 64'(1'b0));
    check_output("rstrun_job_ready", 64'(bus.job_ready_o), 64'(1'b1));
    check_output("rstrun_eng_len", 64'(bus.eng_field_len_o), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    base = starts;
    repeat (40) tick();
    check_output("rstrun_no_start", 64'(starts - base), 64'(0));
    check_output("rstrun_no_done", 64'(done_cnt - dcnt), 64'(0));
    check_output("rstrun_no_err", 64'(err_cnt - ecnt), 64'(0));
    check_output("rstrun_jobs_done", 64'(bus.jobs_done_o), 64'(0));

    // Stale ready during ARM must be ignored.
    do_reset();
    force_ready = 1'b1;
    base = starts;
    push_job(32'h70, 32'd12, 32'h7A);
    wait_for_start(base, "stale_start_seen");
    check_output("stale_done_arm", 64'(bus.done_o), 64'(1'b0));
    tick();
    check_output("stale_done_run", 64'(bus.done_o), 64'(1'b0));
    tick();
    check_output("stale_done_after_run", 64'(bus.done_o), 64'(1'b1));
    force_ready = 1'b0;
    wait_idle("stale_idle");
    check_output("stale_jobs_done", 64'(bus.jobs_done_o), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
